distribute_tree_mcast_sched: RTL

//  Sequencer in front of a log2(NUM_DEST)-level tree of distribute_1x2 cmd-flow switches.

---
 rtl/distribute_tree_mcast_sched_pkg.sv | 23 ++
 rtl/distribute_tree_mcast_sched_if.sv | 32 +++
 rtl/distribute_tree_mcast_sched_req_fifo.sv | 56 +++++
 rtl/distribute_tree_mcast_sched.sv | 104 ++++++++++
 4 files changed

// File: rtl/distribute_tree_mcast_sched_pkg.sv
// Shared definitions for the distribute-tree controllers: issue-state encoding
// and a lowest-set-bit priority encoder that other tree controllers reuse.
package distribute_tree_mcast_sched_pkg;

   // Widest destination mask lsb_index() accepts; callers zero-extend into it.
   localparam int unsigned MAX_DEST = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   // Index of the lowest set bit; LSB wins. Returns 0 for an all-zero vector.
   function automatic logic [4:0] lsb_index(input logic [MAX_DEST-1:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = MAX_DEST - 1; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/distribute_tree_mcast_sched_if.sv
// Request and tree-root issue signals of the multicast sequencer, bundled with
// master (request source / tree side) and slave (sequencer) views.
interface distribute_tree_mcast_sched_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_DEST   = 8,
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned CMD_WIDTH = $clog2(NUM_DEST);
   localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_data_bus;
   logic [NUM_DEST-1:0]   i_dest_mask;
   logic                  o_ready;
   logic                  o_valid;
   logic                  o_en;
   logic [DATA_WIDTH-1:0] o_data_bus;
   logic [CMD_WIDTH-1:0]  o_cmd;
   logic                  i_stall;
   logic                  o_drop;
   logic [CNT_WIDTH-1:0]  o_fifo_count;

   modport master (
      output i_valid, i_data_bus, i_dest_mask, i_stall,
      input  o_ready, o_valid, o_en, o_data_bus, o_cmd, o_drop, o_fifo_count
   );

   modport slave (
      input  i_valid, i_data_bus, i_dest_mask, i_stall,
      output o_ready, o_valid, o_en, o_data_bus, o_cmd, o_drop, o_fifo_count
   );
endinterface

// File: rtl/distribute_tree_mcast_sched_req_fifo.sv
// Synchronous request FIFO; head entry is read combinationally, pointers wrap
// modulo DEPTH (power of two).
module distribute_req_fifo #(
   parameter int unsigned WIDTH = 40,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   // A full FIFO refuses the push even when a pop frees a slot on the same edge.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register regardless of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone decide
   // which entries are valid, so clearing the RAM would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
endmodule

// File: rtl/distribute_tree_mcast_sched.sv
// Multicast sequencer ahead of a distribute_1x2 switch tree: buffers {data, mask}
// requests and serialises each mask into one unicast issue per set bit, LSB first.
module distribute_tree_mcast_sched
   import distribute_tree_mcast_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_DEST   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                      clk,
   input logic                      rst_n,
   distribute_tree_mcast_sched_if.slave bus
);
   localparam int unsigned CMD_WIDTH = $clog2(NUM_DEST);
   localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned ENTRY_W   = DATA_WIDTH + NUM_DEST;
   localparam logic [NUM_DEST-1:0] ONE_MASK = NUM_DEST'(1);

   logic [ENTRY_W-1:0]    fifo_rdata;
   logic                  fifo_full, fifo_empty;
   logic [CNT_WIDTH-1:0]  fifo_count;
   logic [DATA_WIDTH-1:0] head_data;
   logic [NUM_DEST-1:0]   head_mask;
   logic                  ready, accept, push, pop, advance;

   state_e                state_q, state_d;
   logic [NUM_DEST-1:0]   rem_q, rem_d;
   logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  drop_q;

   // Ready depends on registered occupancy only, never on the same-cycle pop.
   assign ready  = rst_n && !fifo_full;
   assign accept = bus.i_valid && ready;
   assign push   = accept && (bus.i_dest_mask != '0);

   distribute_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({bus.i_data_bus, bus.i_dest_mask}),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign {head_data, head_mask} = fifo_rdata;
   assign advance = (state_q == ST_IDLE) || !bus.i_stall;

   // NOTE: every always_comb output gets a default before any branch; a path that
   // left one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      pop     = 1'b0;
      if (advance) begin
         if (rem_q != '0) begin
            state_d = ST_ISSUE;
            cmd_d   = CMD_WIDTH'(lsb_index(MAX_DEST'(rem_q)));
            rem_d   = rem_q & (rem_q - ONE_MASK);
         end else if (!fifo_empty) begin
            // Pop on the same edge that presents the request's first leaf: no bubble.
            pop     = 1'b1;
            state_d = ST_ISSUE;
            data_d  = head_data;
            cmd_d   = CMD_WIDTH'(lsb_index(MAX_DEST'(head_mask)));
            rem_d   = head_mask & (head_mask - ONE_MASK);
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         cmd_q   <= '0;
         data_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         drop_q  <= accept && (bus.i_dest_mask == '0);
      end
   end

   assign bus.o_ready      = ready;
   assign bus.o_valid      = (state_q == ST_ISSUE);
   assign bus.o_en         = (state_q == ST_ISSUE);
   assign bus.o_data_bus   = data_q;
   assign bus.o_cmd        = cmd_q;
   assign bus.o_drop       = drop_q;
   assign bus.o_fifo_count = fifo_count;
endmodule
